frame_controller: RTL and testbench

// - Sequences multi_solver and pixel_iterator frame by frame; owns view window (min/max x/y, dx/dy).
// - Accepts pan/zoom commands, recomputes the window, launches a solve, waits for done, then launches readout.
// - Sits between the user-input decoder and the solver/readout pair.

---
 rtl/frame_controller_if.sv | 42 ++++
 rtl/frame_controller.sv | 189 ++++++++++++++++++
 tb/tb_frame_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_controller_if.sv
// Handshake and window bus between frame_controller (master) and its command/solver/readout peers (slave).
// last_solve_cycles exists only when FRAME_CTRL_PERF_EN is defined.
interface frame_controller_if #(
  parameter int COORD_W = 27
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic                      solve_start;
  logic                      solver_done;
  logic                      readout_start;
  logic                      readout_end;
  logic signed [COORD_W-1:0] min_x;
  logic signed [COORD_W-1:0] min_y;
  logic signed [COORD_W-1:0] max_x;
  logic signed [COORD_W-1:0] max_y;
  logic signed [COORD_W-1:0] dx;
  logic signed [COORD_W-1:0] dy;
  logic                      busy;
  logic [15:0]               frame_count;
`ifdef FRAME_CTRL_PERF_EN
  logic [31:0]               last_solve_cycles;
`endif

  modport master (
    input  cmd_valid, cmd_op, solver_done, readout_end,
    output cmd_ready, solve_start, readout_start,
    output min_x, min_y, max_x, max_y, dx, dy, busy, frame_count
`ifdef FRAME_CTRL_PERF_EN
    , output last_solve_cycles
`endif
  );

  modport slave (
    output cmd_valid, cmd_op, solver_done, readout_end,
    input  cmd_ready, solve_start, readout_start,
    input  min_x, min_y, max_x, max_y, dx, dy, busy, frame_count
`ifdef FRAME_CTRL_PERF_EN
    , input last_solve_cycles
`endif
  );
endinterface

// File: rtl/frame_controller.sv
// Frame sequencer: applies pan/zoom commands to the view window, launches a solve, then a readout.
// Optional FRAME_CTRL_PERF_EN adds a saturating solve-latency counter (last_solve_cycles).
module frame_controller #(
  parameter int COORD_W    = 27,
  parameter int FRAC       = 20,
  parameter int WIDTH      = 99,
  parameter int HEIGHT     = 66,
  parameter int PAN_PIXELS = 8,
  parameter int INIT_DX    = 31776
) (
  input  logic               i_clock,
  input  logic               i_reset,
  frame_controller_if.master bus
);
  localparam int EXT_W = COORD_W + 8;
  typedef logic signed [EXT_W-1:0]   ext_t;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_SOLVE   = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_UP    = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_ZIN   = 3'd5;
  localparam logic [2:0] OP_ZOUT  = 3'd6;
  localparam logic [2:0] OP_HOME  = 3'd7;

  localparam ext_t SPAN_X     = ext_t'(WIDTH - 1);
  localparam ext_t SPAN_Y     = ext_t'(HEIGHT - 1);
  localparam ext_t HALF_X     = ext_t'((WIDTH - 1) >> 1);
  localparam ext_t HALF_Y     = ext_t'((HEIGHT - 1) >> 1);
  localparam ext_t PAN        = ext_t'(PAN_PIXELS);
  localparam ext_t HOME_D     = ext_t'(INIT_DX);
  localparam ext_t HOME_MIN_X = -(ext_t'(2) <<< FRAC);
  localparam ext_t HOME_MIN_Y = -(ext_t'(1) <<< FRAC);
  localparam ext_t HOME_MAX_X = HOME_MIN_X + HOME_D * SPAN_X;
  localparam ext_t HOME_MAX_Y = HOME_MIN_Y + HOME_D * SPAN_Y;
  localparam ext_t C_MIN      = -(ext_t'(1) <<< (COORD_W - 1));
  localparam ext_t C_MAX      = (ext_t'(1) <<< (COORD_W - 1)) - ext_t'(1);

  function automatic logic in_range(input ext_t v);
    return (v >= C_MIN) && (v <= C_MAX);
  endfunction

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_op;
  coord_t     r_min_x, r_min_y, r_max_x, r_max_y, r_d;
  logic       r_cmd_ready, r_busy, r_solve_start, r_readout_start;
  logic [15:0] r_frame_count;

  ext_t w_d, w_min_x, w_min_y, w_cen_x, w_cen_y;
  ext_t w_new_d, w_new_min_x, w_new_min_y, w_new_max_x, w_new_max_y;
  logic w_zoom_floor, w_commit;

  // Candidate window for the latched op, evaluated at extended width so overflow is detectable.
  always_comb begin
    w_d          = ext_t'(r_d);
    w_min_x      = ext_t'(r_min_x);
    w_min_y      = ext_t'(r_min_y);
    w_cen_x      = w_min_x + w_d * HALF_X;
    w_cen_y      = w_min_y + w_d * HALF_Y;
    w_new_d      = w_d;
    w_new_min_x  = w_min_x;
    w_new_min_y  = w_min_y;
    w_zoom_floor = 1'b0;
    case (r_op)
      OP_LEFT:  w_new_min_x = w_min_x - PAN * w_d;
      OP_RIGHT: w_new_min_x = w_min_x + PAN * w_d;
      OP_UP:    w_new_min_y = w_min_y - PAN * w_d;
      OP_DOWN:  w_new_min_y = w_min_y + PAN * w_d;
      OP_ZIN: begin
        w_zoom_floor = (w_d == ext_t'(1));
        w_new_d      = w_d >>> 1;
        w_new_min_x  = w_cen_x - w_new_d * HALF_X;
        w_new_min_y  = w_cen_y - w_new_d * HALF_Y;
      end
      OP_ZOUT: begin
        w_new_d     = w_d <<< 1;
        w_new_min_x = w_cen_x - w_new_d * HALF_X;
        w_new_min_y = w_cen_y - w_new_d * HALF_Y;
      end
      OP_HOME: begin
        w_new_d     = HOME_D;
        w_new_min_x = HOME_MIN_X;
        w_new_min_y = HOME_MIN_Y;
      end
      default: w_new_d = w_d;
    endcase
    w_new_max_x = w_new_min_x + w_new_d * SPAN_X;
    w_new_max_y = w_new_min_y + w_new_d * SPAN_Y;
    w_commit    = !w_zoom_floor && in_range(w_new_d) &&
                  in_range(w_new_min_x) && in_range(w_new_min_y) &&
                  in_range(w_new_max_x) && in_range(w_new_max_y);
  end

  // Next-state logic of the frame sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.cmd_valid) w_next = S_APPLY;   else w_next = S_IDLE;
      S_APPLY:   w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_SOLVE;
      S_SOLVE:   if (bus.solver_done) w_next = S_READOUT; else w_next = S_SOLVE;
      S_READOUT: if (bus.readout_end) w_next = S_IDLE;    else w_next = S_READOUT;
      default:   w_next = S_IDLE;
    endcase
  end

  // State, registered handshake/pulse outputs, window commit and frame counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_op            <= 3'd0;
      r_cmd_ready     <= 1'b1;
      r_busy          <= 1'b0;
      r_solve_start   <= 1'b0;
      r_readout_start <= 1'b0;
      r_frame_count   <= 16'd0;
      r_d             <= coord_t'(HOME_D);
      r_min_x         <= coord_t'(HOME_MIN_X);
      r_min_y         <= coord_t'(HOME_MIN_Y);
      r_max_x         <= coord_t'(HOME_MAX_X);
      r_max_y         <= coord_t'(HOME_MAX_Y);
    end else begin
      r_state         <= w_next;
      r_cmd_ready     <= (w_next == S_IDLE);
      r_busy          <= (w_next != S_IDLE);
      r_solve_start   <= (w_next == S_LAUNCH);
      r_readout_start <= (r_state == S_SOLVE) && (w_next == S_READOUT);
      if (r_state == S_IDLE && bus.cmd_valid) begin
        r_op <= bus.cmd_op;
      end
      if (r_state == S_APPLY && w_commit) begin
        r_d     <= coord_t'(w_new_d);
        r_min_x <= coord_t'(w_new_min_x);
        r_min_y <= coord_t'(w_new_min_y);
        r_max_x <= coord_t'(w_new_max_x);
        r_max_y <= coord_t'(w_new_max_y);
      end
      if (r_state == S_READOUT && bus.readout_end) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.busy          = r_busy;
  assign bus.solve_start   = r_solve_start;
  assign bus.readout_start = r_readout_start;
  assign bus.frame_count   = r_frame_count;
  assign bus.min_x         = r_min_x;
  assign bus.min_y         = r_min_y;
  assign bus.max_x         = r_max_x;
  assign bus.max_y         = r_max_y;
  assign bus.dx            = r_d;
  assign bus.dy            = r_d;

`ifdef FRAME_CTRL_PERF_EN
  logic [31:0] r_solve_cnt;
  logic [31:0] r_last_solve_cycles;

  // Counter reads 1 one cycle after solve_start; captured on the cycle SOLVE sees done.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_solve_cnt         <= 32'd0;
      r_last_solve_cycles <= 32'd0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_solve_cnt <= 32'd1;
      end else if (r_state == S_SOLVE && r_solve_cnt != 32'hFFFF_FFFF) begin
        r_solve_cnt <= r_solve_cnt + 32'd1;
      end
      if (r_state == S_SOLVE && bus.solver_done) begin
        r_last_solve_cycles <= r_solve_cnt;
      end
    end
  end

  assign bus.last_solve_cycles = r_last_solve_cycles;
`endif
endmodule

// File: tb/tb_frame_controller.sv
// Directed self-checking bench for frame_controller; inputs driven and outputs sampled on the falling edge.
module tb_frame_controller;
  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  logic ss_seen;
  logic rs_seen;

  frame_controller_if bus ();

  frame_controller dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.solver_done = 1'b0; bus.readout_end = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete frame with minimal solver and readout latency.
  task automatic run_frame(input logic [2:0] op);
    @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_op = op;
    @(negedge clk); bus.cmd_valid = 1'b0;
    @(negedge clk); ss_seen = bus.solve_start;
    @(negedge clk); bus.solver_done = 1'b1;
    @(negedge clk); bus.solver_done = 1'b0; rs_seen = bus.readout_start; bus.readout_end = 1'b1;
    @(negedge clk); bus.readout_end = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    nvec++; if (bus.min_x !== -27'sd2097152) begin nerr++; $display("FAIL reset_min_x got %0d exp -2097152", bus.min_x); end
    nvec++; if (bus.min_y !== -27'sd1048576) begin nerr++; $display("FAIL reset_min_y got %0d exp -1048576", bus.min_y); end
    nvec++; if (bus.max_x !== 27'sd1016896) begin nerr++; $display("FAIL reset_max_x got %0d exp 1016896", bus.max_x); end
    nvec++; if (bus.max_y !== 27'sd1016864) begin nerr++; $display("FAIL reset_max_y got %0d exp 1016864", bus.max_y); end
    nvec++; if (bus.dx !== 27'sd31776 || bus.dy !== 27'sd31776) begin nerr++; $display("FAIL reset_d got %0d/%0d exp 31776", bus.dx, bus.dy); end
    nvec++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset_flags busy=%b ready=%b exp 0/1", bus.busy, bus.cmd_ready); end
    nvec++; if (bus.frame_count !== 16'd0) begin nerr++; $display("FAIL reset_frame_count got %0d exp 0", bus.frame_count); end
    nvec++; if (bus.solve_start !== 1'b0 || bus.readout_start !== 1'b0) begin nerr++; $display("FAIL reset_pulses got %b%b exp 00", bus.solve_start, bus.readout_start); end
  endtask

  task automatic test_redraw();
    apply_reset();
    @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0;
    nvec++; if (bus.cmd_ready !== 1'b1) begin nerr++; $display("FAIL redraw_ready_idle got %b exp 1", bus.cmd_ready); end
    @(negedge clk); bus.cmd_valid = 1'b0;
    nvec++; if (bus.solve_start !== 1'b0 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin nerr++; $display("FAIL redraw_cycle1 ss=%b busy=%b ready=%b exp 0/1/0", bus.solve_start, bus.busy, bus.cmd_ready); end
    @(negedge clk);
    nvec++; if (bus.solve_start !== 1'b1) begin nerr++; $display("FAIL redraw_solve_start_lat2 got %b exp 1", bus.solve_start); end
    @(negedge clk); bus.solver_done = 1'b1;
    nvec++; if (bus.solve_start !== 1'b0) begin nerr++; $display("FAIL redraw_solve_pulse_width got %b exp 0", bus.solve_start); end
    @(negedge clk); bus.solver_done = 1'b0;
    nvec++; if (bus.readout_start !== 1'b1) begin nerr++; $display("FAIL redraw_readout_start got %b exp 1", bus.readout_start); end
    @(negedge clk);
    nvec++; if (bus.readout_start !== 1'b0 || bus.busy !== 1'b1 || bus.frame_count !== 16'd0) begin nerr++; $display("FAIL redraw_readout_wait rs=%b busy=%b fc=%0d exp 0/1/0", bus.readout_start, bus.busy, bus.frame_count); end
    bus.readout_end = 1'b1;
    @(negedge clk); bus.readout_end = 1'b0;
    nvec++; if (bus.frame_count !== 16'd1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin nerr++; $display("FAIL redraw_done fc=%0d busy=%b ready=%b exp 1/0/1", bus.frame_count, bus.busy, bus.cmd_ready); end
  endtask

  task automatic test_pan();
    apply_reset();
    run_frame(3'd2);
    nvec++; if (bus.min_x !== -27'sd1842944 || bus.max_x !== 27'sd1271104) begin nerr++; $display("FAIL pan_right_x got %0d/%0d exp -1842944/1271104", bus.min_x, bus.max_x); end
    nvec++; if (bus.min_y !== -27'sd1048576 || bus.max_y !== 27'sd1016864) begin nerr++; $display("FAIL pan_right_y got %0d/%0d exp -1048576/1016864", bus.min_y, bus.max_y); end
    nvec++; if (ss_seen !== 1'b1 || rs_seen !== 1'b1) begin nerr++; $display("FAIL pan_right_pulses got %b%b exp 11", ss_seen, rs_seen); end
    run_frame(3'd1);
    run_frame(3'd1);
    nvec++; if (bus.min_x !== -27'sd2351360) begin nerr++; $display("FAIL pan_left got %0d exp -2351360", bus.min_x); end
    run_frame(3'd3);
    nvec++; if (bus.min_y !== -27'sd1302784 || bus.max_y !== 27'sd762656) begin nerr++; $display("FAIL pan_up_y got %0d/%0d exp -1302784/762656", bus.min_y, bus.max_y); end
    run_frame(3'd4);
    nvec++; if (bus.min_y !== -27'sd1048576 || bus.frame_count !== 16'd5) begin nerr++; $display("FAIL pan_down got %0d fc=%0d exp -1048576 fc=5", bus.min_y, bus.frame_count); end
  endtask

  task automatic test_zoom_in();
    apply_reset();
    run_frame(3'd5);
    nvec++; if (bus.dx !== 27'sd15888 || bus.dy !== 27'sd15888) begin nerr++; $display("FAIL zoom_in_d got %0d/%0d exp 15888", bus.dx, bus.dy); end
    nvec++; if (bus.min_x !== -27'sd1318640 || bus.min_y !== -27'sd540160) begin nerr++; $display("FAIL zoom_in_min got %0d/%0d exp -1318640/-540160", bus.min_x, bus.min_y); end
    nvec++; if (bus.max_x !== 27'sd238384) begin nerr++; $display("FAIL zoom_in_max_x got %0d exp 238384", bus.max_x); end
  endtask

  task automatic test_zoom_out_overflow();
    apply_reset();
    for (int i = 0; i < 5; i++) run_frame(3'd6);
    nvec++; if (bus.dx !== 27'sd1016832 || bus.min_x !== -27'sd50364896 || bus.max_x !== 27'sd49284640) begin nerr++; $display("FAIL zoom_out5_x got d=%0d %0d/%0d exp 1016832 -50364896/49284640", bus.dx, bus.min_x, bus.max_x); end
    nvec++; if (bus.min_y !== -27'sd32570368 || bus.max_y !== 27'sd33523712) begin nerr++; $display("FAIL zoom_out5_y got %0d/%0d exp -32570368/33523712", bus.min_y, bus.max_y); end
    run_frame(3'd6);
    nvec++; if (bus.dx !== 27'sd1016832 || bus.min_x !== -27'sd50364896 || bus.max_y !== 27'sd33523712) begin nerr++; $display("FAIL zoom_out_overflow got d=%0d min_x=%0d max_y=%0d exp unchanged", bus.dx, bus.min_x, bus.max_y); end
    nvec++; if (bus.frame_count !== 16'd6 || ss_seen !== 1'b1) begin nerr++; $display("FAIL zoom_out_overflow_frame fc=%0d ss=%b exp 6/1", bus.frame_count, ss_seen); end
    run_frame(3'd7);
    nvec++; if (bus.dx !== 27'sd31776 || bus.min_x !== -27'sd2097152 || bus.max_y !== 27'sd1016864) begin nerr++; $display("FAIL home got d=%0d min_x=%0d max_y=%0d exp 31776/-2097152/1016864", bus.dx, bus.min_x, bus.max_y); end
  endtask

  task automatic test_zoom_in_floor();
    apply_reset();
    for (int i = 0; i < 14; i++) run_frame(3'd5);
    nvec++; if (bus.dx !== 27'sd1) begin nerr++; $display("FAIL zoom_floor_reach got %0d exp 1", bus.dx); end
    run_frame(3'd5);
    nvec++; if (bus.dx !== 27'sd1 || bus.dy !== 27'sd1) begin nerr++; $display("FAIL zoom_floor_hold got %0d/%0d exp 1", bus.dx, bus.dy); end
    nvec++; if (bus.frame_count !== 16'd15) begin nerr++; $display("FAIL zoom_floor_frames got %0d exp 15", bus.frame_count); end
  endtask

  task automatic test_flood();
    int bad;
    bad = 0;
    apply_reset();
    @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.cmd_ready !== 1'b0) bad++;
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL flood_ready_low got %0d high cycles exp 0", bad); end
    bus.solver_done = 1'b1;
    @(negedge clk); bus.solver_done = 1'b0; bus.readout_end = 1'b1;
    nvec++; if (bus.cmd_ready !== 1'b0) begin nerr++; $display("FAIL flood_ready_readout got %b exp 0", bus.cmd_ready); end
    @(negedge clk); bus.readout_end = 1'b0; bus.cmd_valid = 1'b0;
    nvec++; if (bus.cmd_ready !== 1'b1 || bus.min_x !== -27'sd2351360 || bus.frame_count !== 16'd1) begin nerr++; $display("FAIL flood_single_accept ready=%b min_x=%0d fc=%0d exp 1/-2351360/1", bus.cmd_ready, bus.min_x, bus.frame_count); end
    @(negedge clk);
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL flood_idle got busy=%b exp 0", bus.busy); end
  endtask

  task automatic test_stray_handshakes();
    apply_reset();
    @(negedge clk); bus.solver_done = 1'b1; bus.readout_end = 1'b1;
    @(negedge clk); bus.solver_done = 1'b0; bus.readout_end = 1'b0;
    @(negedge clk);
    nvec++; if (bus.busy !== 1'b0 || bus.readout_start !== 1'b0 || bus.frame_count !== 16'd0) begin nerr++; $display("FAIL stray_idle busy=%b rs=%b fc=%0d exp 0/0/0", bus.busy, bus.readout_start, bus.frame_count); end
    @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0;
    @(negedge clk); bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.solver_done = 1'b1; bus.readout_end = 1'b1;
    @(negedge clk); bus.solver_done = 1'b0; bus.readout_end = 1'b0;
    nvec++; if (bus.readout_start !== 1'b1 || bus.busy !== 1'b1 || bus.frame_count !== 16'd0) begin nerr++; $display("FAIL done_end_same_cycle rs=%b busy=%b fc=%0d exp 1/1/0", bus.readout_start, bus.busy, bus.frame_count); end
    @(negedge clk); bus.readout_end = 1'b1;
    @(negedge clk); bus.readout_end = 1'b0;
    nvec++; if (bus.frame_count !== 16'd1 || bus.busy !== 1'b0) begin nerr++; $display("FAIL done_end_finish fc=%0d busy=%b exp 1/0", bus.frame_count, bus.busy); end
  endtask

  task automatic test_reset_readout();
    apply_reset();
    @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2;
    @(negedge clk); bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.solver_done = 1'b1;
    @(negedge clk); bus.solver_done = 1'b0;
    nvec++; if (bus.min_x !== -27'sd1842944 || bus.busy !== 1'b1) begin nerr++; $display("FAIL rst_readout_pre min_x=%0d busy=%b exp -1842944/1", bus.min_x, bus.busy); end
    rst = 1'b1; bus.readout_end = 1'b1;
    @(negedge clk); rst = 1'b0; bus.readout_end = 1'b0;
    nvec++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.readout_start !== 1'b0) begin nerr++; $display("FAIL rst_readout_idle busy=%b ready=%b rs=%b exp 0/1/0", bus.busy, bus.cmd_ready, bus.readout_start); end
    nvec++; if (bus.min_x !== -27'sd2097152 || bus.max_x !== 27'sd1016896) begin nerr++; $display("FAIL rst_readout_home got %0d/%0d exp -2097152/1016896", bus.min_x, bus.max_x); end
    nvec++; if (bus.frame_count !== 16'd0) begin nerr++; $display("FAIL rst_readout_count got %0d exp 0", bus.frame_count); end
  endtask

`ifdef FRAME_CTRL_PERF_EN
  task automatic test_perf();
    apply_reset();
    nvec++; if (bus.last_solve_cycles !== 32'd0) begin nerr++; $display("FAIL perf_reset got %0d exp 0", bus.last_solve_cycles); end
    @(negedge clk); bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0;
    @(negedge clk); bus.cmd_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) @(negedge clk);
    bus.solver_done = 1'b1;
    @(negedge clk); bus.solver_done = 1'b0; bus.readout_end = 1'b1;
    @(negedge clk); bus.readout_end = 1'b0;
    nvec++; if (bus.last_solve_cycles !== 32'd100) begin nerr++; $display("FAIL perf_100 got %0d exp 100", bus.last_solve_cycles); end
  endtask
`endif

  initial begin
    nvec = 0;
    nerr = 0;
    ss_seen = 1'b0;
    rs_seen = 1'b0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.solver_done = 1'b0;
    bus.readout_end = 1'b0;
    test_reset();
    test_redraw();
    test_pan();
    test_zoom_in();
    test_zoom_out_overflow();
    test_zoom_in_floor();
    test_flood();
    test_stray_handshakes();
    test_reset_readout();
`ifdef FRAME_CTRL_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
